operand_wakeup_station: RTL and testbench

Parametrised operand-capture reservation station between rename/dispatch and a functional unit.
- Resolves each source operand at dispatch using a fixed priority: zero, PC, RAT, ROB, then a same-cycle CDB bypass.
- Parks instructions whose operands are still pending and snoops up to `NUM_CDB` result buses every cycle.
- Issues the oldest fully-ready entry over a valid/ready handshake.
- Generalises the single-operand, single-cycle operand manager to `NUM_SRC` operands, `DEPTH` buffered entries and sequential wakeup.

---
 rtl/operand_wakeup_station_pkg.sv | 23 ++
 rtl/operand_wakeup_station_if.sv | 59 +++++
 rtl/operand_wakeup_station_cdb_snoop.sv | 29 ++
 rtl/operand_wakeup_station.sv | 202 ++++++++++++++++++++
 tb/tb_operand_wakeup_station.sv | 366 ++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/operand_wakeup_station_pkg.sv
// operand_wakeup_station shared package
// Source-select and entry-state encodings
package operand_wakeup_station_pkg;

  localparam int ROB_ENTRY_WIDTH = 4;

  localparam logic [1:0] SRC_ZERO = 2'd0;
  localparam logic [1:0] SRC_PC   = 2'd1;
  localparam logic [1:0] SRC_REG  = 2'd2;

  typedef enum logic [1:0] {
    ST_FREE  = 2'd0,
    ST_WAIT  = 2'd1,
    ST_READY = 2'd2
  } ent_st_e;

  function automatic logic is_reg_src(
    input logic [1:0] sel
  );
    return |(sel & SRC_REG);
  endfunction

endpackage

// File: rtl/operand_wakeup_station_if.sv
// operand_wakeup_station bus interface
// Dispatch, CDB and issue signals
interface operand_wakeup_station_if #(
  parameter int XLEN    = 32,
  parameter int TAG_W   = 4,
  parameter int NUM_SRC = 2,
  parameter int NUM_CDB = 3,
  parameter int OP_W    = 8
);

  logic                      disp_valid;
  logic                      disp_ready;
  logic [OP_W-1:0]           disp_op;
  logic [TAG_W-1:0]          disp_dest_tag;
  logic [XLEN-1:0]           disp_pc;
  logic [2*NUM_SRC-1:0]      disp_src_sel;
  logic [NUM_SRC-1:0]        disp_rat_valid;
  logic [XLEN*NUM_SRC-1:0]   disp_rat_value;
  logic [NUM_SRC-1:0]        disp_rob_ready;
  logic [XLEN*NUM_SRC-1:0]   disp_rob_value;
  logic [TAG_W*NUM_SRC-1:0]  disp_rob_tag;

  logic [NUM_CDB-1:0]        cdb_valid;
  logic [TAG_W*NUM_CDB-1:0]  cdb_tag;
  logic [XLEN*NUM_CDB-1:0]   cdb_data;

  logic                      issue_valid;
  logic                      issue_ready;
  logic [OP_W-1:0]           issue_op;
  logic [TAG_W-1:0]          issue_dest_tag;
  logic [XLEN*NUM_SRC-1:0]   issue_src;

  modport master (
    output disp_valid, disp_op, disp_dest_tag,
    output disp_pc, disp_src_sel,
    output disp_rat_valid, disp_rat_value,
    output disp_rob_ready, disp_rob_value,
    output disp_rob_tag,
    output cdb_valid, cdb_tag, cdb_data,
    output issue_ready,
    input  disp_ready,
    input  issue_valid, issue_op,
    input  issue_dest_tag, issue_src
  );

  modport slave (
    input  disp_valid, disp_op, disp_dest_tag,
    input  disp_pc, disp_src_sel,
    input  disp_rat_valid, disp_rat_value,
    input  disp_rob_ready, disp_rob_value,
    input  disp_rob_tag,
    input  cdb_valid, cdb_tag, cdb_data,
    input  issue_ready,
    output disp_ready,
    output issue_valid, issue_op,
    output issue_dest_tag, issue_src
  );

endinterface

// File: rtl/operand_wakeup_station_cdb_snoop.sv
// cdb_snoop: one tag against all CDB channels
// Lowest channel index wins on multiple hits
module cdb_snoop #(
  parameter int XLEN    = 32,
  parameter int TAG_W   = 4,
  parameter int NUM_CDB = 3
) (
  input  logic [TAG_W-1:0]         i_tag,
  input  logic [NUM_CDB-1:0]       i_cdb_valid,
  input  logic [TAG_W*NUM_CDB-1:0] i_cdb_tag,
  input  logic [XLEN*NUM_CDB-1:0]  i_cdb_data,
  output logic                     o_hit,
  output logic [XLEN-1:0]          o_data
);

  // scan high to low so the lowest hit lands last
  always_comb begin
    o_hit  = 1'b0;
    o_data = '0;
    for (int c = NUM_CDB-1; c >= 0; c--) begin
      if (i_cdb_valid[c] && (i_tag != '0) &&
          (i_cdb_tag[c*TAG_W +: TAG_W] == i_tag)) begin
        o_hit  = 1'b1;
        o_data = i_cdb_data[c*XLEN +: XLEN];
      end
    end
  end

endmodule

// File: rtl/operand_wakeup_station.sv
// operand_wakeup_station top
// Operand-capture reservation station with CDB wakeup
module operand_wakeup_station
  import operand_wakeup_station_pkg::*;
#(
  parameter int XLEN    = 32,
  parameter int TAG_W   = ROB_ENTRY_WIDTH,
  parameter int NUM_SRC = 2,
  parameter int NUM_CDB = 3,
  parameter int DEPTH   = 4,
  parameter int OP_W    = 8
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   flush,
  operand_wakeup_station_if.slave bus,
  output logic [$clog2(DEPTH):0] occupancy
);

  localparam int IDX_W = $clog2(DEPTH);
  localparam int OCC_W = IDX_W + 1;
  localparam int AGE_W = TAG_W + 2;

  ent_st_e            r_st   [DEPTH];
  logic [OP_W-1:0]    r_op   [DEPTH];
  logic [TAG_W-1:0]   r_dest [DEPTH];
  logic [AGE_W-1:0]   r_age  [DEPTH];
  logic [NUM_SRC-1:0] r_pend [DEPTH];
  logic [TAG_W-1:0]   r_tag  [DEPTH][NUM_SRC];
  logic [XLEN-1:0]    r_val  [DEPTH][NUM_SRC];
  logic [AGE_W-1:0]   r_age_cnt;

  logic [NUM_SRC-1:0] w_byp_hit;
  logic [XLEN-1:0]    w_byp_data [NUM_SRC];
  logic [NUM_SRC-1:0] w_wk_hit   [DEPTH];
  logic [XLEN-1:0]    w_wk_data  [DEPTH][NUM_SRC];

  logic [NUM_SRC-1:0] w_d_pend;
  logic [XLEN-1:0]    w_d_val [NUM_SRC];
  logic [1:0]         w_ss;
  logic [IDX_W-1:0]   w_alloc;
  logic [IDX_W-1:0]   w_sel;
  logic               w_sel_vld;
  logic [AGE_W-1:0]   w_diff;
  logic [OCC_W-1:0]   w_occ;
  logic               w_disp_fire;
  logic               w_iss_fire;

  for (genvar s = 0; s < NUM_SRC; s++) begin : g_byp
    cdb_snoop #(
      .XLEN(XLEN), .TAG_W(TAG_W), .NUM_CDB(NUM_CDB)
    ) u_snoop (
      .i_tag      (bus.disp_rob_tag[s*TAG_W +: TAG_W]),
      .i_cdb_valid(bus.cdb_valid),
      .i_cdb_tag  (bus.cdb_tag),
      .i_cdb_data (bus.cdb_data),
      .o_hit      (w_byp_hit[s]),
      .o_data     (w_byp_data[s])
    );
  end

  for (genvar e = 0; e < DEPTH; e++) begin : g_ent
    for (genvar s = 0; s < NUM_SRC; s++) begin : g_src
      cdb_snoop #(
        .XLEN(XLEN), .TAG_W(TAG_W), .NUM_CDB(NUM_CDB)
      ) u_snoop (
        .i_tag      (r_tag[e][s]),
        .i_cdb_valid(bus.cdb_valid),
        .i_cdb_tag  (bus.cdb_tag),
        .i_cdb_data (bus.cdb_data),
        .o_hit      (w_wk_hit[e][s]),
        .o_data     (w_wk_data[e][s])
      );
    end
  end

  // resolve dispatch operands: zero, PC, RAT, ROB, bypass
  always_comb begin
    w_d_pend = '0;
    w_ss     = '0;
    for (int s = 0; s < NUM_SRC; s++) begin
      w_d_val[s] = '0;
      w_ss = bus.disp_src_sel[2*s +: 2];
      if (w_ss == SRC_ZERO) begin
        w_d_val[s] = '0;
      end else if (w_ss == SRC_PC) begin
        w_d_val[s] = bus.disp_pc;
      end else if (is_reg_src(w_ss)) begin
        if (bus.disp_rat_valid[s])
          w_d_val[s] = bus.disp_rat_value[s*XLEN +: XLEN];
        else if (bus.disp_rob_ready[s])
          w_d_val[s] = bus.disp_rob_value[s*XLEN +: XLEN];
        else if (w_byp_hit[s])
          w_d_val[s] = w_byp_data[s];
        else
          w_d_pend[s] = 1'b1;
      end
    end
  end

  // lowest-index free entry
  always_comb begin
    w_alloc = '0;
    for (int i = DEPTH-1; i >= 0; i--)
      if (r_st[i] == ST_FREE)
        w_alloc = IDX_W'(i);
  end

  // oldest ready entry by wrap-safe age
  always_comb begin
    w_sel     = '0;
    w_sel_vld = 1'b0;
    w_diff    = '0;
    for (int i = 0; i < DEPTH; i++) begin
      w_diff = r_age[i] - r_age[w_sel];
      if (r_st[i] == ST_READY &&
          (!w_sel_vld || w_diff[AGE_W-1])) begin
        w_sel     = IDX_W'(i);
        w_sel_vld = 1'b1;
      end
    end
  end

  // count of occupied entries
  always_comb begin
    w_occ = '0;
    for (int i = 0; i < DEPTH; i++)
      w_occ = w_occ + OCC_W'(r_st[i] != ST_FREE);
  end

  assign occupancy      = w_occ;
  assign bus.disp_ready = (w_occ < OCC_W'(DEPTH));
  assign w_disp_fire    = bus.disp_valid & bus.disp_ready;
  assign w_iss_fire     = w_sel_vld & bus.issue_ready;

  // issue outputs, zeroed when nothing is ready
  always_comb begin
    bus.issue_valid    = w_sel_vld;
    bus.issue_op       = '0;
    bus.issue_dest_tag = '0;
    bus.issue_src      = '0;
    if (w_sel_vld) begin
      bus.issue_op       = r_op[w_sel];
      bus.issue_dest_tag = r_dest[w_sel];
      for (int s = 0; s < NUM_SRC; s++)
        bus.issue_src[s*XLEN +: XLEN] = r_val[w_sel][s];
    end
  end

  // entry state: wakeup, issue free, allocate, flush
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_age_cnt <= '0;
      for (int e = 0; e < DEPTH; e++) begin
        r_st[e]   <= ST_FREE;
        r_op[e]   <= '0;
        r_dest[e] <= '0;
        r_age[e]  <= '0;
        r_pend[e] <= '0;
        for (int s = 0; s < NUM_SRC; s++) begin
          r_tag[e][s] <= '0;
          r_val[e][s] <= '0;
        end
      end
    end else if (flush) begin
      r_age_cnt <= '0;
      for (int e = 0; e < DEPTH; e++)
        r_st[e] <= ST_FREE;
    end else begin
      for (int e = 0; e < DEPTH; e++) begin
        if (r_st[e] == ST_WAIT) begin
          for (int s = 0; s < NUM_SRC; s++) begin
            if (r_pend[e][s] && w_wk_hit[e][s]) begin
              r_val[e][s] <= w_wk_data[e][s];
              r_tag[e][s] <= '0;
            end
          end
          r_pend[e] <= r_pend[e] & ~w_wk_hit[e];
          if ((r_pend[e] & ~w_wk_hit[e]) == '0)
            r_st[e] <= ST_READY;
        end
      end
      if (w_iss_fire)
        r_st[w_sel] <= ST_FREE;
      if (w_disp_fire) begin
        r_st[w_alloc]   <= (w_d_pend != '0) ? ST_WAIT
                                            : ST_READY;
        r_op[w_alloc]   <= bus.disp_op;
        r_dest[w_alloc] <= bus.disp_dest_tag;
        r_age[w_alloc]  <= r_age_cnt;
        r_pend[w_alloc] <= w_d_pend;
        for (int s = 0; s < NUM_SRC; s++) begin
          r_val[w_alloc][s] <= w_d_val[s];
          r_tag[w_alloc][s] <= w_d_pend[s]
            ? bus.disp_rob_tag[s*TAG_W +: TAG_W] : '0;
        end
        r_age_cnt <= r_age_cnt + AGE_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_operand_wakeup_station.sv
// tb_operand_wakeup_station
// Directed and random checks against a queue model
module tb_operand_wakeup_station;

  localparam int DEPTH = 4;

  typedef struct {
    logic [7:0]       op;
    logic [3:0]       dest;
    logic [1:0]       pend;
    logic [1:0][3:0]  tag;
    logic [1:0][31:0] val;
  } ent_t;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       flush;
  logic [2:0] occupancy;

  int n_checks = 0;
  int n_errors = 0;

  ent_t q[$];

  operand_wakeup_station_if #(
    .XLEN(32), .TAG_W(4), .NUM_SRC(2),
    .NUM_CDB(3), .OP_W(8)
  ) bus ();

  operand_wakeup_station #(
    .XLEN(32), .TAG_W(4), .NUM_SRC(2),
    .NUM_CDB(3), .DEPTH(4), .OP_W(8)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .flush    (flush),
    .bus      (bus),
    .occupancy(occupancy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm,
                     input logic [63:0] obs,
                     input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %0h expected %0h",
             nm, obs, exp);
    end
  endtask

  task automatic clr();
    flush              = 1'b0;
    bus.disp_valid     = 1'b0;
    bus.disp_op        = '0;
    bus.disp_dest_tag  = '0;
    bus.disp_pc        = '0;
    bus.disp_src_sel   = '0;
    bus.disp_rat_valid = '0;
    bus.disp_rat_value = '0;
    bus.disp_rob_ready = '0;
    bus.disp_rob_value = '0;
    bus.disp_rob_tag   = '0;
    bus.cdb_valid      = '0;
    bus.cdb_tag        = '0;
    bus.cdb_data       = '0;
    bus.issue_ready    = 1'b0;
  endtask

  task automatic disp(input logic [7:0] op,
                      input logic [3:0] dest,
                      input logic [31:0] pc);
    bus.disp_valid    = 1'b1;
    bus.disp_op       = op;
    bus.disp_dest_tag = dest;
    bus.disp_pc       = pc;
  endtask

  task automatic set_src(input int s,
                         input logic [1:0] sel,
                         input logic rv,
                         input logic [31:0] rval,
                         input logic bv,
                         input logic [31:0] bval,
                         input logic [3:0] tag);
    bus.disp_src_sel[2*s +: 2]     = sel;
    bus.disp_rat_valid[s]          = rv;
    bus.disp_rat_value[32*s +: 32] = rval;
    bus.disp_rob_ready[s]          = bv;
    bus.disp_rob_value[32*s +: 32] = bval;
    bus.disp_rob_tag[4*s +: 4]     = tag;
  endtask

  task automatic set_cdb(input int c,
                         input logic [3:0] t,
                         input logic [31:0] d);
    bus.cdb_valid[c]        = 1'b1;
    bus.cdb_tag[4*c +: 4]   = t;
    bus.cdb_data[32*c +: 32] = d;
  endtask

  function automatic bit cdb_find(input logic [3:0] t,
                                  output logic [31:0] d);
    d = '0;
    for (int c = 0; c < 3; c++) begin
      if (bus.cdb_valid[c] && bus.cdb_tag[4*c +: 4] != 0
          && bus.cdb_tag[4*c +: 4] == t) begin
        d = bus.cdb_data[32*c +: 32];
        return 1'b1;
      end
    end
    return 1'b0;
  endfunction

  function automatic ent_t resolve();
    ent_t e;
    logic [31:0] d;
    logic [1:0] sl;
    e.op   = bus.disp_op;
    e.dest = bus.disp_dest_tag;
    e.pend = '0;
    e.tag  = '0;
    e.val  = '0;
    for (int s = 0; s < 2; s++) begin
      sl = bus.disp_src_sel[2*s +: 2];
      if (sl == 2'd0)
        e.val[s] = '0;
      else if (sl == 2'd1)
        e.val[s] = bus.disp_pc;
      else if (bus.disp_rat_valid[s])
        e.val[s] = bus.disp_rat_value[32*s +: 32];
      else if (bus.disp_rob_ready[s])
        e.val[s] = bus.disp_rob_value[32*s +: 32];
      else if (cdb_find(bus.disp_rob_tag[4*s +: 4], d))
        e.val[s] = d;
      else begin
        e.pend[s] = 1'b1;
        e.tag[s]  = bus.disp_rob_tag[4*s +: 4];
      end
    end
    return e;
  endfunction

  function automatic int oldest_ready();
    foreach (q[k])
      if (q[k].pend == 2'b00)
        return k;
    return -1;
  endfunction

  task automatic check_outputs();
    int k;
    logic [7:0]  eop;
    logic [3:0]  edst;
    logic [63:0] esrc;
    k    = oldest_ready();
    eop  = '0;
    edst = '0;
    esrc = '0;
    if (k >= 0) begin
      eop  = q[k].op;
      edst = q[k].dest;
      esrc = {q[k].val[1], q[k].val[0]};
    end
    chk("occupancy", 64'(occupancy), 64'(q.size()));
    chk("disp_ready", 64'(bus.disp_ready),
        64'(q.size() < DEPTH));
    chk("issue_valid", 64'(bus.issue_valid), 64'(k >= 0));
    chk("issue_op", 64'(bus.issue_op), 64'(eop));
    chk("issue_dest", 64'(bus.issue_dest_tag), 64'(edst));
    chk("issue_src", bus.issue_src, esrc);
  endtask

  task automatic model_edge();
    int k;
    bit acc;
    ent_t e;
    logic [31:0] d;
    k = oldest_ready();
    if (flush) begin
      q.delete();
      return;
    end
    acc = bus.disp_valid && (q.size() < DEPTH);
    if (acc)
      e = resolve();
    if (k >= 0 && bus.issue_ready)
      q.delete(k);
    foreach (q[i]) begin
      for (int s = 0; s < 2; s++) begin
        if (q[i].pend[s] && cdb_find(q[i].tag[s], d)) begin
          q[i].val[s]  = d;
          q[i].pend[s] = 1'b0;
        end
      end
    end
    if (acc)
      q.push_back(e);
  endtask

  task automatic cycle();
    #1;
    check_outputs();
    model_edge();
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    clr();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_occ", 64'(occupancy), 64'd0);
    chk("rst_disp_ready", 64'(bus.disp_ready), 64'd1);
    chk("rst_issue_valid", 64'(bus.issue_valid), 64'd0);
    rst_n = 1'b1;
    cycle();

    // PC + RAT operands, ready at dispatch
    clr();
    disp(8'h11, 4'd1, 32'h100);
    set_src(0, 2'd1, 0, 0, 0, 0, 0);
    set_src(1, 2'd2, 1, 32'h55, 0, 0, 0);
    bus.issue_ready = 1'b1;
    cycle();
    clr();
    bus.issue_ready = 1'b1;
    chk("t1_valid", 64'(bus.issue_valid), 64'd1);
    chk("t1_src", bus.issue_src, 64'h00000055_00000100);
    cycle();

    // same-cycle bypass, ALU beats LSQ
    clr();
    disp(8'h22, 4'd2, 32'h0);
    set_src(0, 2'd2, 0, 0, 0, 0, 4'd5);
    set_src(1, 2'd0, 0, 0, 0, 0, 0);
    set_cdb(0, 4'd5, 32'hA);
    set_cdb(1, 4'd5, 32'hB);
    bus.issue_ready = 1'b1;
    cycle();
    clr();
    bus.issue_ready = 1'b1;
    chk("t2_valid", 64'(bus.issue_valid), 64'd1);
    chk("t2_src", bus.issue_src, 64'h0000000A);
    cycle();

    // fill, wake all on BRA, drain in order
    for (int i = 0; i < 4; i++) begin
      clr();
      disp(8'(8'h30 + i), 4'(i + 1), 32'(32'h200 + i));
      set_src(0, 2'd3, 0, 0, 0, 0, 4'd3);
      set_src(1, 2'd1, 0, 0, 0, 0, 0);
      cycle();
    end
    clr();
    chk("t3_full", 64'(bus.disp_ready), 64'd0);
    chk("t3_occ4", 64'(occupancy), 64'd4);
    disp(8'hEE, 4'd9, 32'h0);
    set_cdb(2, 4'd3, 32'h333);
    cycle();
    for (int i = 0; i < 4; i++) begin
      clr();
      bus.issue_ready = 1'b1;
      chk("t3_occ", 64'(occupancy), 64'(4 - i));
      chk("t3_order", 64'(bus.issue_op), 64'(8'h30 + i));
      chk("t3_drdy", 64'(bus.disp_ready), 64'(i != 0));
      cycle();
    end
    chk("t3_empty", 64'(occupancy), 64'd0);

    // tag 0 broadcast must not touch anything
    clr();
    disp(8'h44, 4'd4, 32'h0);
    set_src(0, 2'd2, 0, 0, 0, 0, 4'd7);
    set_src(1, 2'd2, 1, 32'h55, 0, 0, 0);
    cycle();
    clr();
    for (int c = 0; c < 3; c++)
      set_cdb(c, 4'd0, 32'hFF);
    cycle();
    clr();
    chk("t4_wait", 64'(bus.issue_valid), 64'd0);
    set_cdb(1, 4'd7, 32'h77);
    cycle();
    clr();
    bus.issue_ready = 1'b1;
    chk("t4_src", bus.issue_src, 64'h00000055_00000077);
    cycle();

    // flush beats dispatch and wakeup
    for (int i = 0; i < 2; i++) begin
      clr();
      disp(8'(8'h50 + i), 4'd5, 32'h0);
      set_src(0, 2'd2, 0, 0, 0, 0, 4'd9);
      cycle();
    end
    clr();
    flush = 1'b1;
    disp(8'h5F, 4'd6, 32'h0);
    set_cdb(0, 4'd9, 32'h99);
    bus.issue_ready = 1'b1;
    cycle();
    clr();
    chk("t5_occ", 64'(occupancy), 64'd0);
    chk("t5_nothing", 64'(bus.issue_valid), 64'd0);
    disp(8'h55, 4'd7, 32'h0);
    cycle();
    clr();
    bus.issue_ready = 1'b1;
    chk("t5_next", 64'(bus.issue_op), 64'h55);
    cycle();

    // async reset with waiting entries
    for (int i = 0; i < 3; i++) begin
      clr();
      disp(8'(8'h60 + i), 4'd8, 32'h0);
      set_src(1, 2'd2, 0, 0, 0, 0, 4'hE);
      cycle();
    end
    clr();
    chk("t6_pre_occ", 64'(occupancy), 64'd3);
    rst_n = 1'b0;
    #1;
    chk("t6_occ", 64'(occupancy), 64'd0);
    chk("t6_drdy", 64'(bus.disp_ready), 64'd1);
    chk("t6_valid", 64'(bus.issue_valid), 64'd0);
    chk("t6_op", 64'(bus.issue_op), 64'd0);
    chk("t6_dest", 64'(bus.issue_dest_tag), 64'd0);
    chk("t6_src", bus.issue_src, 64'd0);
    q.delete();
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    // random traffic against the model
    for (int n = 0; n < 400; n++) begin
      clr();
      flush = ($urandom_range(0, 39) == 0);
      bus.disp_valid     = 1'($urandom_range(0, 1));
      bus.disp_op        = 8'($urandom);
      bus.disp_dest_tag  = 4'($urandom_range(1, 15));
      bus.disp_pc        = $urandom;
      bus.disp_src_sel   = 4'($urandom);
      bus.disp_rat_valid = 2'($urandom) & 2'($urandom);
      bus.disp_rat_value = {$urandom, $urandom};
      bus.disp_rob_ready = 2'($urandom) & 2'($urandom);
      bus.disp_rob_value = {$urandom, $urandom};
      bus.disp_rob_tag   = {4'($urandom_range(1, 4)),
                            4'($urandom_range(1, 4))};
      bus.cdb_valid      = 3'($urandom) | 3'b011;
      bus.cdb_tag        = {4'($urandom_range(1, 4)),
                            4'($urandom_range(1, 4)),
                            4'($urandom_range(1, 4))};
      bus.cdb_data       = {$urandom, $urandom, $urandom};
      bus.issue_ready    = ($urandom_range(0, 3) != 0);
      cycle();
    end

    $display("Simulation finished: %0d checks, %0d errors",
             n_checks, n_errors);
    $finish;
  end

endmodule
